// File: rtl/adc_pkg.sv
// Shared ADC datapath parameters. The decimator and the sample FIFO both
// take their widths from here, so the two ends of the link always agree.
//
// Contents:
//   ADC_DATA_WIDTH   width of a decimated sample
//   DECIM_OUT_WIDTH  decimator output width (the same value by construction)
//   FIFO_DEPTH_LOG2  default sample FIFO depth, log2
//   fifo_depth()     depth in entries for a given log2 depth
package adc_pkg;

    localparam int ADC_DATA_WIDTH  = 32;
    localparam int DECIM_OUT_WIDTH = ADC_DATA_WIDTH;
    localparam int FIFO_DEPTH_LOG2 = 4;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/adc_sample_fifo_if.sv
// Bundle of every sample FIFO signal except the clock and the reset.
//
// Modports:
//   master  producer/consumer side. It drives the write strobe, the sample,
//           the pop request, the flush and the threshold, and it observes
//           the read data and the status outputs.
//   slave   FIFO side. The directions are the reverse of master.
interface adc_sample_fifo_if
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
);
    logic                  sample_valid_in;
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  rd_en_in;
    logic                  clear_in;
    logic [DEPTH_LOG2:0]   thresh_in;
    logic [DATA_WIDTH-1:0] rd_data_out;
    logic                  rd_valid_out;
    logic [DEPTH_LOG2:0]   level_out;
    logic                  empty_out;
    logic                  full_out;
    logic                  overflow_out;
    logic                  underflow_out;
    logic                  irq_out;

    modport master (
        output sample_valid_in, sample_in, rd_en_in, clear_in, thresh_in,
        input  rd_data_out, rd_valid_out, level_out, empty_out, full_out,
               overflow_out, underflow_out, irq_out
    );

    modport slave (
        input  sample_valid_in, sample_in, rd_en_in, clear_in, thresh_in,
        output rd_data_out, rd_valid_out, level_out, empty_out, full_out,
               overflow_out, underflow_out, irq_out
    );

endinterface

// File: rtl/adc_fifo_mem.sv
// Sample storage for the ADC FIFO. It has one write port and one registered
// read port, and it has no reset.
//
// Ports:
//   clk    clock
//   we     write enable; writes wdata to waddr
//   waddr  write address
//   wdata  write data
//   re     read enable; loads rdata from raddr on the next edge
//   raddr  read address
//   rdata  registered read data. It holds its value while re=0.
//
// When a read and a write hit the same address on the same edge, the read
// returns the old contents. That case occurs when the FIFO is full and a push
// and a pop happen together.
module adc_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO that sits between the decimator and the reader. It buffers
// signed samples, reports its fill level, and raises an interrupt when the
// level reaches a threshold.
//
// Ports:
//   clk  sole clock; all logic runs on posedge clk
//   rst  synchronous reset, active high
//   bus  adc_sample_fifo_if.slave, which carries the write strobe and sample,
//        the pop request, the flush, the threshold, the read data with its
//        valid pulse, the level, empty/full, the sticky overflow/underflow
//        flags and irq
//
// The read and write pointers wrap modulo the depth. The level is a separate
// counter, which is how full and empty are told apart. All status outputs
// are registered.
module adc_sample_fifo
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input logic clk,
    input logic rst,
    adc_sample_fifo_if.slave bus
);

    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = fifo_depth(DEPTH_LOG2);

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [LW-1:0]         level;
    logic [LW-1:0]         level_nxt;
    logic                  empty_q;
    logic                  full_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  irq_q;
    logic                  rd_valid_q;
    logic                  has_data;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_q;

    // A pop on an empty FIFO is rejected even when a push arrives in the same
    // cycle, so data never bypasses the storage. A push into a full FIFO is
    // accepted only when a pop frees a slot in that same cycle.
    assign pop_ok  = bus.rd_en_in && !empty_q;
    assign push_ok = bus.sample_valid_in && (!full_q || pop_ok);

    // A reset or a flush discards any push or pop in the same cycle.
    assign mem_we = push_ok && !bus.clear_in && !rst;
    assign mem_re = pop_ok  && !bus.clear_in && !rst;

    adc_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wptr),
        .wdata(bus.sample_in),
        .re   (mem_re),
        .raddr(rptr),
        .rdata(mem_q)
    );

    always_comb begin
        level_nxt = level;
        if (push_ok && !pop_ok) begin
            level_nxt = level + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            has_data    <= 1'b0;
        end else if (bus.clear_in) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= (bus.thresh_in != '0) && (level >= bus.thresh_in);
            rd_valid_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rptr     <= rptr + DEPTH_LOG2'(1);
                has_data <= 1'b1;
            end
            level      <= level_nxt;
            empty_q    <= (level_nxt == '0);
            full_q     <= (level_nxt == LW'(DEPTH));
            rd_valid_q <= pop_ok;
            if (bus.sample_valid_in && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en_in && empty_q) begin
                underflow_q <= 1'b1;
            end
            // irq follows the registered level, so it trails level_out by one cycle.
            irq_q <= (bus.thresh_in != '0) && (level >= bus.thresh_in);
        end
    end

    // The read register inside the storage has no reset. has_data forces the
    // read data to zero until the first pop after reset.
    assign bus.rd_data_out   = has_data ? mem_q : '0;
    assign bus.rd_valid_out  = rd_valid_q;
    assign bus.level_out     = level;
    assign bus.empty_out     = empty_q;
    assign bus.full_out      = full_q;
    assign bus.overflow_out  = overflow_q;
    assign bus.underflow_out = underflow_q;
    assign bus.irq_out       = irq_q;

endmodule
